// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
//   Three requesters share one chip8_ram instance. The RAM has one read port,
//   one write port and 1-cycle registered read data. The ports are CPU (0),
//   PPU (1) and display scanout (2). One access is granted per cycle and is
//   issued to the RAM in that same cycle. Read data comes back one cycle later
//   on the shared rdata bus, qualified by a per-port rvalid. A requester can
//   hold a lock to make a multi-cycle sequence atomic. MAX_LOCK bounds how long
//   a lock may be held.
//
//   Optional feature (macro ARB_SCANOUT_PRIO_EN):
//   - Scanout has strict priority in the FREE state, and ports 0/1 round-robin.
//   - While scanout requests, a running lock is cut short at min(MAX_LOCK, 4).
//   - The port 2 lock input is ignored.
//
//   Ports
//     clk, reset            clock, asynchronous active-low reset
//     req/lock/we[2:0]      per-port request, lock, write enable
//     addrN / wdataN        per-port address and write data
//     gnt[2:0]              one-hot grant (combinational)
//     rvalid[2:0], rdata    read return, one cycle after a read grant
//     mem_*                 chip8_ram read/write port
module chip8_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {ST_FREE, ST_LOCKED} state_t;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_last_q, rr_last_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_port_q, pend_port_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

  logic [2:0]        gnt_int;
  logic [2:0]        lock_eff;
  logic [7:0]        lock_limit;

  // Round-robin pick: search starts at the port after 'last'.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      2'd0:    if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001;
      2'd1:    if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010;
      default: if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100;
    endcase
    return g;
  endfunction

  function automatic logic [2:0] arb_free(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
`ifdef ARB_SCANOUT_PRIO_EN
    if (r[2]) g = 3'b100;
    else      g = rr_pick({1'b0, r[1:0]}, last);
`else
    g = rr_pick(r, last);
`endif
    return g;
  endfunction

  function automatic logic [1:0] enc(input logic [2:0] oh);
    logic [1:0] p;
    case (oh)
      3'b010:  p = 2'd1;
      3'b100:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

`ifdef ARB_SCANOUT_PRIO_EN
  assign lock_eff   = lock & 3'b011;
  assign lock_limit = (req[2] && (MAX_LOCK_C > 8'd4)) ? 8'd4 : MAX_LOCK_C;
`else
  assign lock_eff   = lock;
  assign lock_limit = MAX_LOCK_C;
`endif

  // Arbitration and lock state
  always_comb begin
    logic [2:0] mask;
    logic [1:0] g;
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = rr_last_q;
    gnt_int    = 3'b000;
    mask       = req;
    g          = 2'd0;
    if (state_q == ST_LOCKED && req[owner_q] && lock_eff[owner_q]) begin
      gnt_int    = 3'b001 << owner_q;
      rr_last_d  = owner_q;
      lock_cnt_d = lock_cnt_q + 8'd1;
      // The grant that reaches the limit is the owner's last one; the owner
      // then ranks lowest in the following round-robin cycle.
      if (lock_cnt_d >= lock_limit) begin
        state_d    = ST_FREE;
        lock_cnt_d = 8'd0;
      end
    end else begin
      // A dropped lock releases without a grant to the old owner this cycle.
      if (state_q == ST_LOCKED) mask[owner_q] = 1'b0;
      gnt_int    = arb_free(mask, rr_last_q);
      state_d    = ST_FREE;
      lock_cnt_d = 8'd0;
      if (gnt_int != 3'b000) begin
        g         = enc(gnt_int);
        rr_last_d = g;
        if (lock_eff[g] && (lock_limit > 8'd1)) begin
          state_d    = ST_LOCKED;
          owner_d    = g;
          lock_cnt_d = 8'd1;
        end
      end
    end
  end

  // Grant drops as soon as reset is asserted, not at the next edge.
  assign gnt = reset ? gnt_int : 3'b000;

  // RAM drive and read-return bookkeeping
  always_comb begin
    logic [1:0]        g;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    raddr_d          = raddr_q;
    waddr_d          = waddr_q;
    wdat_d           = wdat_q;
    mem_write_enable = 1'b0;
    pend_valid_d     = 1'b0;
    pend_port_d      = pend_port_q;
    g                = enc(gnt);
    case (g)
      2'd1:    begin a = addr1; d = wdata1; end
      2'd2:    begin a = addr2; d = wdata2; end
      default: begin a = addr0; d = wdata0; end
    endcase
    if (gnt != 3'b000) begin
      if (we[g]) begin
        waddr_d          = a;
        wdat_d           = d;
        mem_write_enable = 1'b1;
      end else begin
        raddr_d      = a;
        pend_valid_d = 1'b1;
        pend_port_d  = g;
      end
    end
  end

  assign mem_read_address  = raddr_d;
  assign mem_write_address = waddr_d;
  assign mem_write_data    = wdat_d;
  assign rvalid            = pend_valid_q ? (3'b001 << pend_port_q) : 3'b000;
  assign rdata             = pend_valid_q ? mem_read_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FREE;
      owner_q      <= 2'd0;
      rr_last_q    <= 2'd2;
      lock_cnt_q   <= 8'd0;
      pend_valid_q <= 1'b0;
      pend_port_q  <= 2'd0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      wdat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      lock_cnt_q   <= lock_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_port_q  <= pend_port_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      wdat_q       <= wdat_d;
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
module tb_chip8_mem_arbiter;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 8;
  localparam int MAX_LOCK = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        req, lock, we;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [DATA_W-1:0] wdata0, wdata1, wdata2;
  logic [2:0]        gnt, rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_read_address, mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  chip8_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // RAM model: registered read data, synchronous write.
  logic [7:0] ram    [0:4095];
  logic [7:0] shadow [0:4095];
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
    mem_read_data <= ram[mem_read_address];
  end

  typedef struct {
    string      name;
    logic [2:0] req, lock, we;
    logic [11:0] a0, a1, a2;
    logic [7:0] wd;
    logic [2:0] exp_gnt;
  } vec_t;

  typedef struct {
    logic [2:0] rv;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] r, input logic [2:0] l,
                              input logic [2:0] w, input logic [11:0] a0, input logic [11:0] a1,
                              input logic [11:0] a2, input logic [7:0] wd, input logic [2:0] eg);
    vec_t v;
    v.name = n; v.req = r; v.lock = l; v.we = w;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd; v.exp_gnt = eg;
    return v;
  endfunction

  // Drive one cycle, check the grant and RAM drive, check the read return
  // owed from the previous cycle, and queue this cycle's expected return.
  task automatic step(input vec_t v);
    exp_t e, ne;
    int   g;
    logic [11:0] a;
    req = v.req; lock = v.lock; we = v.we;
    addr0 = v.a0; addr1 = v.a1; addr2 = v.a2;
    wdata0 = v.wd; wdata1 = v.wd; wdata2 = v.wd;
    @(negedge clk);
    chk({v.name, " gnt"}, 32'(gnt), 32'(v.exp_gnt));
    if (sb.size() == 0) begin e.rv = 3'b000; e.data = 8'h00; end
    else e = sb.pop_front();
    chk({v.name, " rvalid"}, 32'(rvalid), 32'(e.rv));
    if (e.rv != 3'b000) chk({v.name, " rdata"}, 32'(rdata), 32'(e.data));
    ne.rv = 3'b000; ne.data = 8'h00;
    if (v.exp_gnt == 3'b000) begin
      chk({v.name, " mem_we"}, 32'(mem_write_enable), 32'd0);
    end else begin
      g = (v.exp_gnt == 3'b001) ? 0 : (v.exp_gnt == 3'b010) ? 1 : 2;
      a = (g == 0) ? v.a0 : (g == 1) ? v.a1 : v.a2;
      if (v.we[g]) begin
        chk({v.name, " mem_we"}, 32'(mem_write_enable), 32'd1);
        chk({v.name, " waddr"}, 32'(mem_write_address), 32'(a));
        chk({v.name, " wdata"}, 32'(mem_write_data), 32'(v.wd));
        shadow[a] = v.wd;
      end else begin
        chk({v.name, " mem_we"}, 32'(mem_write_enable), 32'd0);
        chk({v.name, " raddr"}, 32'(mem_read_address), 32'(a));
        ne.rv = v.exp_gnt;
        ne.data = shadow[a];
      end
    end
    sb.push_back(ne);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = 3'b000; lock = 3'b000; we = 3'b000;
    #2 reset = 1'b0;
    #1;
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst raddr", 32'(mem_read_address), 32'd0);
    chk("rst waddr", 32'(mem_write_address), 32'd0);
    chk("rst wdata", 32'(mem_write_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  vec_t idle;

  initial begin
    req = 3'b000; lock = 3'b000; we = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    ram[12'h22A] = 8'h0F; shadow[12'h22A] = 8'h0F;
    ram[12'h141] = 8'h3C; shadow[12'h141] = 8'h3C;

    idle = mk("idle", 3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 3'b000);
    tbl[0] = mk("cpu_rd",  3'b001, 3'b000, 3'b000, 12'h22A, 12'h000, 12'h000, 8'h00, 3'b001);
    tbl[1] = idle;
    tbl[2] = mk("rmw_rd",  3'b010, 3'b010, 3'b000, 12'h22A, 12'h141, 12'h000, 8'h00, 3'b010);
    tbl[3] = mk("rmw_wr",  3'b011, 3'b010, 3'b010, 12'h300, 12'h141, 12'h000, 8'hF0, 3'b010);
    tbl[4] = mk("rmw_p0",  3'b001, 3'b000, 3'b000, 12'h300, 12'h141, 12'h000, 8'h00, 3'b001);
    tbl[5] = mk("rmw_chk", 3'b010, 3'b000, 3'b000, 12'h300, 12'h141, 12'h000, 8'h00, 3'b010);
    tbl[6] = idle;

    do_reset();
    for (int i = 0; i < 7; i++) step(tbl[i]);
    chk("ram_141", 32'(ram[12'h141]), 32'h0000_00F0);

`ifndef ARB_SCANOUT_PRIO_EN
    // All three ports read continuously from reset.
    do_reset();
    step(mk("rr0", 3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b001));
    step(mk("rr1", 3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b010));
    step(mk("rr2", 3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b100));
    step(mk("rr3", 3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b001));
    step(idle);
`else
    do_reset();
    step(mk("prio0", 3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b100));
    step(idle);
    do_reset();
    step(mk("plk0", 3'b010, 3'b010, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b010));
    for (int i = 0; i < 3; i++)
      step(mk("plk", 3'b110, 3'b010, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b010));
    step(mk("plk_rel", 3'b110, 3'b010, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b100));
    step(idle);
`endif

    // Lock limit: port 0 last granted, so port 1 wins and locks; the owner
    // gets MAX_LOCK grants, then port 0 gets exactly one.
    do_reset();
    step(mk("lim_pre", 3'b001, 3'b000, 3'b000, 12'h055, 12'h000, 12'h000, 8'h00, 3'b001));
    for (int i = 0; i < 40; i++)
      step(mk("lock_lim", 3'b011, 3'b010, 3'b000, 12'h055, 12'h141, 12'h000, 8'h00,
              ((i % (MAX_LOCK + 1)) < MAX_LOCK) ? 3'b010 : 3'b001));
    step(idle);

    // Reset one cycle after a read grant: result discarded.
    do_reset();
    step(mk("mid_rd", 3'b001, 3'b000, 3'b000, 12'h22A, 12'h000, 12'h000, 8'h00, 3'b001));
    reset = 1'b0;
    #1;
    chk("mid_rst gnt", 32'(gnt), 32'd0);
    chk("mid_rst rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst mem_we", 32'(mem_write_enable), 32'd0);
    req = 3'b000;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
`ifndef ARB_SCANOUT_PRIO_EN
    step(mk("post_rst", 3'b111, 3'b000, 3'b000, 12'h011, 12'h021, 12'h031, 8'h00, 3'b001));
`else
    step(mk("post_rst", 3'b111, 3'b000, 3'b000, 12'h011, 12'h021, 12'h031, 8'h00, 3'b100));
`endif
    step(idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares the single chip8_ram instance (one read port, one write port, 1-cycle registered read data) between three requesters: CPU (port 0), PPU (port 1) and display scanout (port 2).
- Grants one access per cycle and routes read data back to the issuing requester.
- Supports a lock for atomic multi-cycle sequences, such as the PPU's sprite-read / framebuffer read-modify-write.
- Sits between the requesters and chip8_ram in the top level.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_LOCK, 16, maximum consecutive cycles one requester may hold a lock before forced release (valid range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req[2:0]  in  3  per-port access request; bit index = port number.
- lock[2:0]  in  3  per-port lock; meaningful only while the same port's req bit is high.
- we[2:0]  in  3  per-port write enable (1 = write, 0 = read).
- addr0/addr1/addr2  in  ADDR_W  per-port address.
- wdata0/wdata1/wdata2  in  DATA_W  per-port write data.
- gnt[2:0]  out  3  one-hot grant; access is issued to the RAM in the same cycle.
- rvalid[2:0]  out  3  read-data-valid, one cycle after a granted read.
- rdata  out  DATA_W  shared read data; qualified by rvalid.
- mem_read_address  out  ADDR_W  to RAM.
- mem_write_address  out  ADDR_W  to RAM.
- mem_write_data  out  DATA_W  to RAM.
- mem_write_enable  out  1  to RAM.
- mem_read_data  in  DATA_W  from RAM (registered q).

Behaviour:
- Reset values (asserted asynchronously):
  - gnt=0, rvalid=0, mem_write_enable=0.
  - Addresses and data outputs = 0.
  - rr_last=2, so port 0 is first in the order.
  - lock_cnt=0, owner=none.
- Grant timing:
  - gnt is combinational from req and the registered state.
  - At most one gnt bit is high per cycle.
  - gnt=0 whenever req=0.
- Arbitration, no owner: round-robin starting at (rr_last+1) mod 3. The first port with req=1 wins, and rr_last is updated to it at the clock edge.
- State machine:
  - FREE: no owner. A grant to port p with lock[p]=1 moves to LOCKED(p) with lock_cnt=1.
  - LOCKED(p): port p is granted every cycle while req[p]=1, regardless of other requests, and lock_cnt increments.
  - Release to FREE in the same cycle any of these hold:
    - req[p]=0 or lock[p]=0: no grant to p that cycle; RR applies that cycle.
    - lock_cnt==MAX_LOCK: p still gets this cycle's grant; the next cycle is arbitrated with p lowest (rr_last=p).
- RAM drive when granted port g exists:
  - Read: mem_read_address=addr_g, mem_write_enable=0.
  - Write: mem_write_address=addr_g, mem_write_data=wdata_g, mem_write_enable=1.
- RAM drive when no grant: mem_write_enable=0; addresses hold their last value.
- Read return:
  - Registered pend_port and pend_valid.
  - rvalid[pend_port]=1 exactly one cycle after a read grant; rdata=mem_read_data.
  - Writes never raise rvalid.
  - Back-to-back reads from different ports each return in order, one per cycle.
- Requester rules:
  - A requester holds addr, we and wdata stable while req=1 and gnt=0.
  - A new access may be presented the cycle after gnt.
- Simultaneous events:
  - lock rising on a port that is not currently granted has no effect until that port wins.
  - If all three ports request in FREE state with rr_last=2, port 0 wins, then 1, then 2.
- Reset mid-operation: gnt, rvalid and owner clear immediately; an in-flight read result is discarded (no rvalid).

Optional Feature:
- ARB_SCANOUT_PRIO_EN.
- Defined:
  - In FREE state port 2 (scanout) is strict highest priority; ports 0/1 round-robin among themselves.
  - A LOCKED owner is not preempted, but while req[2]=1 the effective lock limit is min(MAX_LOCK, 4).
  - Port 2 lock input is ignored.
- Undefined: pure 3-way round-robin as above; all ports may lock.

Test Plan:
- Single CPU read, addr0=0x22A, RAM[0x22A]=0x0F:
  - gnt=001 the same cycle.
  - rvalid=001 the next cycle with rdata=0x0F.
  - No write strobe.
- All three ports request reads continuously after reset:
  - Grants sequence 001,010,100,001.
  - Each rvalid follows its grant by one cycle.
  - Data matches each port's address.
- PPU lock RMW:
  - Port 1 reads 0x141, then writes 0xF0 to 0x141 with lock=1 while port 0 requests.
  - gnt=010 for both cycles; port 0 is granted on the third cycle.
  - RAM[0x141]=0xF0.
- Lock limit, MAX_LOCK=16:
  - Port 1 holds req=1, lock=1 for 40 cycles while port 0 requests.
  - Port 1 is granted for exactly 16 cycles, then port 0 gets 1 grant.
- Reset mid-read:
  - reset=0 asserted asynchronously one cycle after a read grant.
  - gnt=0 and rvalid=0 immediately.
  - No rvalid after release; the first grant after release goes to port 0.
- With ARB_SCANOUT_PRIO_EN:
  - Ports 0, 1 and 2 all request from FREE; gnt=100 first.
  - Port 1 locked with port 2 requesting: port 1 releases after 4 cycles, then gnt=100.
